// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, decoded-instruction output, branch redirect.
// Latency: none, this is a wiring bundle only.
// Backpressure: imem_gnt stalls requests; instr_ready stalls the instruction head.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr, instr_valid, instr, opcode, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );

    // Environment side: memory, decode stage and branch unit
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, opcode, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, 2-entry {instr, pc} buffer, redirect flush.
// Latency: 4th cycle after reset release with zero-wait memory; steady state one instruction per 3 cycles.
// Backpressure: no new request while 2 entries buffered; head held stable until instr_ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] req_pc_q;
    logic        imem_req_q;
    logic [31:0] imem_addr_q;

    logic [31:0] buf_instr_q [2];
    logic [31:0] buf_pc_q    [2];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  count_q;

    logic        push;
    logic        pop;
    logic        head_vld;
    logic [31:0] redirect_pc_al;

    assign redirect_pc_al = {bus.redirect_pc[31:2], 2'b00};
    assign head_vld       = (count_q != 2'd0);
    // A redirect in the same cycle discards the response, so it never pushes.
    assign push           = (state_q == WAIT) && bus.imem_rvalid && !bus.redirect;
    assign pop            = head_vld && bus.instr_ready;

    // Fetch FSM with registered request outputs; imem_addr reads 0 when no request is up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= '0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.redirect) begin
                        fetch_pc_q <= redirect_pc_al;
                    end else if (count_q <= 2'd1) begin
                        state_q     <= REQ;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= fetch_pc_q;
                    end
                end
                REQ: begin
                    if (bus.imem_gnt) begin
                        req_pc_q    <= fetch_pc_q;
                        imem_req_q  <= 1'b0;
                        imem_addr_q <= '0;
                        if (bus.redirect) begin
                            // Request already accepted: its response must be swallowed.
                            state_q    <= DROP;
                            fetch_pc_q <= redirect_pc_al;
                        end else begin
                            state_q    <= WAIT;
                            fetch_pc_q <= fetch_pc_q + 32'd4;
                        end
                    end else if (bus.redirect) begin
                        // Not yet accepted, so simply withdraw the request.
                        state_q     <= IDLE;
                        imem_req_q  <= 1'b0;
                        imem_addr_q <= '0;
                        fetch_pc_q  <= redirect_pc_al;
                    end
                end
                WAIT: begin
                    if (bus.redirect) begin
                        fetch_pc_q <= redirect_pc_al;
                        state_q    <= bus.imem_rvalid ? IDLE : DROP;
                    end else if (bus.imem_rvalid) begin
                        state_q <= IDLE;
                    end
                end
                DROP: begin
                    if (bus.redirect) begin
                        fetch_pc_q <= redirect_pc_al;
                    end
                    // The stale response retires here even if a new redirect arrives with it,
                    // otherwise the FSM would wait for a response that never comes.
                    if (bus.imem_rvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Two-entry instruction buffer; redirect flushes it ahead of any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_instr_q[i] <= '0;
                buf_pc_q[i]    <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (bus.redirect) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                buf_instr_q[wr_ptr_q] <= bus.imem_rdata;
                buf_pc_q[wr_ptr_q]    <= req_pc_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = imem_addr_q;
    assign bus.instr_valid = head_vld;
    assign bus.instr       = head_vld ? buf_instr_q[rd_ptr_q] : 32'd0;
    assign bus.instr_pc    = head_vld ? buf_pc_q[rd_ptr_q]    : 32'd0;
    assign bus.opcode      = bus.instr[31:26];

endmodule
